// File: rtl/msi_snoop_controller.sv
// MSI snooping coherence controller: N private direct-mapped tag/state arrays,
// a round-robin arbiter onto one snoop bus, and a single transaction FSM that
// sequences lookup, victim write-back, snoop broadcast, owner write-back and fill.
module msi_snoop_controller #(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned LINES      = 4,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_CORES-1:0]            req_valid,
    input  logic [NUM_CORES-1:0]            req_write,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_CORES-1:0]            req_done,
    output logic                            req_hit,
    output logic                            bus_read_miss,
    output logic                            bus_write_miss,
    output logic                            bus_invalidate,
    output logic                            write_back,
    output logic                            abort_memory_access,
    output logic                            mem_req,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic                            mem_ack,
    input  logic [$clog2(NUM_CORES)-1:0]    dbg_core,
    input  logic [$clog2(LINES)-1:0]        dbg_index,
    output logic [1:0]                      dbg_state
);

    localparam int unsigned CoreW = $clog2(NUM_CORES);
    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned TagW  = ADDR_WIDTH - IdxW;

    localparam logic [1:0] MsiI = 2'b00;
    localparam logic [1:0] MsiS = 2'b01;
    localparam logic [1:0] MsiM = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StLookup, StVictimWb, StSnoop, StOwnerWb, StFill, StDone
    } fsm_e;

    fsm_e                  state_q, state_d;
    logic [CoreW-1:0]      core_q, core_d;
    logic [CoreW-1:0]      rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  hit_q, hit_d;
    logic                  upgrade_q, upgrade_d;
    logic [TagW-1:0]       victim_tag_q, victim_tag_d;

    logic [TagW-1:0] tag_q  [NUM_CORES][LINES];
    logic [TagW-1:0] tag_d  [NUM_CORES][LINES];
    logic [1:0]      line_q [NUM_CORES][LINES];
    logic [1:0]      line_d [NUM_CORES][LINES];

    logic [NUM_CORES-1:0]  req_done_q, req_done_d;
    logic                  req_hit_q, req_hit_d;
    logic                  bus_rm_q, bus_rm_d, bus_wm_q, bus_wm_d, bus_inv_q, bus_inv_d;
    logic                  wb_q, wb_d, abort_q, abort_d;
    logic                  mem_req_q, mem_req_d, mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [IdxW-1:0] req_idx;
    logic [TagW-1:0] req_tag;
    logic [TagW-1:0] look_tag;
    logic [1:0]      look_st;
    logic            look_match;

    assign req_idx    = addr_q[IdxW-1:0];
    assign req_tag    = addr_q[ADDR_WIDTH-1:IdxW];
    assign look_tag   = tag_q[core_q][req_idx];
    assign look_st    = line_q[core_q][req_idx];
    // Encoding 11 is never written, so it never counts as a valid copy.
    assign look_match = (look_tag == req_tag) && (look_st == MsiS || look_st == MsiM);

    // Next transaction state, array updates and next registered outputs.
    always_comb begin
        int unsigned cand;
        logic        found;
        logic        owner;
        cand         = 0;
        found        = 1'b0;
        owner        = 1'b0;
        state_d      = state_q;
        core_d       = core_q;
        rr_d         = rr_q;
        addr_d       = addr_q;
        write_d      = write_q;
        hit_d        = hit_q;
        upgrade_d    = upgrade_q;
        victim_tag_d = victim_tag_q;
        tag_d        = tag_q;
        line_d       = line_q;

        unique case (state_q)
            StIdle: begin
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    cand = (32'(rr_q) + i) % NUM_CORES;
                    if (!found && req_valid[cand]) begin
                        found   = 1'b1;
                        core_d  = CoreW'(cand);
                        addr_d  = req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
                        write_d = req_write[cand];
                        rr_d    = CoreW'((cand + 1) % NUM_CORES);
                    end
                end
                if (found) state_d = StLookup;
            end
            StLookup: begin
                upgrade_d = 1'b0;
                hit_d     = 1'b0;
                if (look_match && (!write_q || look_st == MsiM)) begin
                    hit_d   = 1'b1;
                    state_d = StDone;
                end else if (look_match) begin
                    hit_d     = 1'b1;
                    upgrade_d = 1'b1;
                    state_d   = StSnoop;
                end else if (look_st == MsiM) begin
                    // Dirty line of a different tag must reach memory first.
                    victim_tag_d = look_tag;
                    state_d      = StVictimWb;
                end else begin
                    state_d = StSnoop;
                end
            end
            StVictimWb: begin
                if (mem_ack) begin
                    line_d[core_q][req_idx] = MsiI;
                    state_d                 = StSnoop;
                end
            end
            StSnoop: begin
                for (int unsigned c = 0; c < NUM_CORES; c++) begin
                    if (c != 32'(core_q) && tag_q[c][req_idx] == req_tag &&
                        (line_q[c][req_idx] == MsiS || line_q[c][req_idx] == MsiM)) begin
                        if (line_q[c][req_idx] == MsiM) owner = 1'b1;
                        if (upgrade_q || write_q) line_d[c][req_idx] = MsiI;
                        else                      line_d[c][req_idx] = MsiS;
                    end
                end
                if (owner)          state_d = StOwnerWb;
                else if (upgrade_q) state_d = StDone;
                else                state_d = StFill;
            end
            StOwnerWb: if (mem_ack) state_d = StDone;
            StFill:    if (mem_ack) state_d = StDone;
            StDone: begin
                tag_d[core_q][req_idx]  = req_tag;
                line_d[core_q][req_idx] = write_q ? MsiM : MsiS;
                state_d                 = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        mem_req_d   = (state_d == StVictimWb) || (state_d == StOwnerWb) || (state_d == StFill);
        mem_write_d = (state_d == StVictimWb) || (state_d == StOwnerWb);
        wb_d        = mem_write_d;
        if (state_d == StVictimWb) mem_addr_d = {victim_tag_d, addr_d[IdxW-1:0]};
        else if (mem_req_d)        mem_addr_d = addr_d;
        else                       mem_addr_d = '0;
        bus_rm_d   = (state_d == StSnoop) && !upgrade_d && !write_d;
        bus_wm_d   = (state_d == StSnoop) && !upgrade_d && write_d;
        bus_inv_d  = (state_d == StSnoop) && upgrade_d;
        abort_d    = (state_q == StOwnerWb) && (state_d == StDone);
        req_done_d = '0;
        if (state_d == StDone) req_done_d[core_d] = 1'b1;
        req_hit_d  = (state_d == StDone) && hit_d;
    end

    // All state and registered outputs; reset clears every line to I.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            core_q       <= '0;
            rr_q         <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            hit_q        <= 1'b0;
            upgrade_q    <= 1'b0;
            victim_tag_q <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int l = 0; l < LINES; l++) begin
                    tag_q[c][l]  <= '0;
                    line_q[c][l] <= MsiI;
                end
            end
            req_done_q  <= '0;
            req_hit_q   <= 1'b0;
            bus_rm_q    <= 1'b0;
            bus_wm_q    <= 1'b0;
            bus_inv_q   <= 1'b0;
            wb_q        <= 1'b0;
            abort_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            core_q       <= core_d;
            rr_q         <= rr_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            hit_q        <= hit_d;
            upgrade_q    <= upgrade_d;
            victim_tag_q <= victim_tag_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
            req_done_q   <= req_done_d;
            req_hit_q    <= req_hit_d;
            bus_rm_q     <= bus_rm_d;
            bus_wm_q     <= bus_wm_d;
            bus_inv_q    <= bus_inv_d;
            wb_q         <= wb_d;
            abort_q      <= abort_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign req_done            = req_done_q;
    assign req_hit             = req_hit_q;
    assign bus_read_miss       = bus_rm_q;
    assign bus_write_miss      = bus_wm_q;
    assign bus_invalidate      = bus_inv_q;
    assign write_back          = wb_q;
    assign abort_memory_access = abort_q;
    assign mem_req             = mem_req_q;
    assign mem_write           = mem_write_q;
    assign mem_addr            = mem_addr_q;
    assign dbg_state           = line_q[dbg_core][dbg_index];

endmodule

// File: tb/tb_msi_snoop_controller.sv
// Directed bench for msi_snoop_controller at default parameters.
module tb_msi_snoop_controller;

    localparam int NC = 2;
    localparam int AW = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NC-1:0]    req_valid, req_write, req_done;
    logic [NC*AW-1:0] req_addr;
    logic             req_hit, bus_read_miss, bus_write_miss, bus_invalidate;
    logic             write_back, abort_memory_access, mem_req, mem_write, mem_ack;
    logic [AW-1:0]    mem_addr;
    logic [0:0]       dbg_core;
    logic [1:0]       dbg_index;
    logic [1:0]       dbg_state;

    msi_snoop_controller #(.NUM_CORES(2), .LINES(4), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_done(req_done), .req_hit(req_hit),
        .bus_read_miss(bus_read_miss), .bus_write_miss(bus_write_miss),
        .bus_invalidate(bus_invalidate), .write_back(write_back),
        .abort_memory_access(abort_memory_access),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .dbg_core(dbg_core), .dbg_index(dbg_index), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-run observations.
    int            lat;
    int            n_done, n_rm, n_wm, n_inv, n_abort, n_acc, n_multi;
    int            done_core [4];
    int            done_hit  [4];
    int            done_cyc  [4];
    logic [AW-1:0] acc_addr  [4];
    int            acc_wr    [4];

    task automatic set_req(input int core, input int wr, input logic [AW-1:0] addr);
        req_write[core]          = wr[0];
        req_addr[core*AW +: AW]  = addr;
        req_valid[core]          = 1'b1;
    endtask

    // Runs cycles as memory model and monitor until `want` completions or a timeout.
    task automatic run_until(input int want);
        int cyc  = 0;
        int wcnt = 0;
        n_done = 0; n_rm = 0; n_wm = 0; n_inv = 0; n_abort = 0; n_acc = 0; n_multi = 0;
        while (n_done < want && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (bus_read_miss)       n_rm++;
            if (bus_write_miss)      n_wm++;
            if (bus_invalidate)      n_inv++;
            if (abort_memory_access) n_abort++;
            if (mem_req) begin
                if (wcnt == lat) begin
                    mem_ack = 1'b1;
                    if (n_acc < 4) begin
                        acc_addr[n_acc] = mem_addr;
                        acc_wr[n_acc]   = int'(mem_write);
                    end
                    n_acc++;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
            if (req_done != '0) begin
                if ($countones(req_done) != 1) n_multi++;
                for (int c = 0; c < NC; c++) begin
                    if (req_done[c] && n_done < 4) begin
                        done_core[n_done] = c;
                        done_hit[n_done]  = int'(req_hit);
                        done_cyc[n_done]  = cyc;
                        req_valid[c]      = 1'b0;
                        n_done++;
                    end
                end
            end
        end
        mem_ack = 1'b0;
        if (n_done < want) check("timeout_done_count", n_done, want);
    endtask

    task automatic check_dbg(input string name, input int core, input int idx, input int exp);
        dbg_core  = core[0:0];
        dbg_index = idx[1:0];
        #1;
        check(name, dbg_state, exp);
    endtask

    typedef struct {
        int            core;
        int            wr;
        logic [AW-1:0] addr;
        int            lat;
        int            hit;
        int            cyc;
        int            rm;
        int            wm;
        int            inv;
        int            abort;
        int            nacc;
        logic [AW-1:0] a0;
        int            w0;
        logic [AW-1:0] a1;
        int            w1;
        int            st0;
        int            st1;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // core wr addr lat | hit cyc rm wm inv abort nacc a0 w0 a1 w1 | st0 st1
        vecs[0]  = '{0, 0, 8'h15, 1, 0, 5, 1, 0, 0, 0, 1, 8'h15, 0, 8'h00, 0, 1, 0};
        vecs[1]  = '{0, 0, 8'h15, 0, 1, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0};
        vecs[2]  = '{1, 0, 8'h15, 0, 0, 4, 1, 0, 0, 0, 1, 8'h15, 0, 8'h00, 0, 1, 1};
        vecs[3]  = '{0, 1, 8'h15, 0, 1, 3, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 2, 0};
        vecs[4]  = '{1, 0, 8'h15, 1, 0, 5, 1, 0, 0, 1, 1, 8'h15, 1, 8'h00, 0, 1, 1};
        vecs[5]  = '{0, 1, 8'h15, 0, 1, 3, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 2, 0};
        vecs[6]  = '{0, 0, 8'h25, 0, 0, 5, 1, 0, 0, 0, 2, 8'h15, 1, 8'h25, 0, 1, 0};
        vecs[7]  = '{0, 0, 8'h25, 0, 1, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0};
        vecs[8]  = '{1, 1, 8'h25, 0, 0, 4, 0, 1, 0, 0, 1, 8'h25, 0, 8'h00, 0, 0, 2};
        vecs[9]  = '{0, 1, 8'h25, 0, 0, 4, 0, 1, 0, 1, 1, 8'h25, 1, 8'h00, 0, 2, 0};
        vecs[10] = '{1, 0, 8'h26, 0, 0, 4, 1, 0, 0, 0, 1, 8'h26, 0, 8'h00, 0, 0, 1};
        vecs[11] = '{0, 1, 8'h11, 1, 0, 7, 0, 1, 0, 0, 2, 8'h25, 1, 8'h11, 0, 2, 0};
        vecs[12] = '{1, 0, 8'h26, 0, 1, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1};

        reset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        mem_ack = 1'b0; dbg_core = '0; dbg_index = '0; lat = 0;
        #12;
        check("reset_outputs",
              {req_done, req_hit, bus_read_miss, bus_write_miss, bus_invalidate,
               write_back, abort_memory_access, mem_req, mem_write}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check_dbg("reset_dbg_c1_i3", 1, 3, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            set_req(vecs[i].core, vecs[i].wr, vecs[i].addr);
            run_until(1);
            check($sformatf("v%0d_done_core", i), done_core[0], vecs[i].core);
            check($sformatf("v%0d_hit", i), done_hit[0], vecs[i].hit);
            check($sformatf("v%0d_latency", i), done_cyc[0], vecs[i].cyc);
            check($sformatf("v%0d_bus", i), {n_rm[7:0], n_wm[7:0], n_inv[7:0]},
                  {vecs[i].rm[7:0], vecs[i].wm[7:0], vecs[i].inv[7:0]});
            check($sformatf("v%0d_abort", i), n_abort, vecs[i].abort);
            check($sformatf("v%0d_mem_accesses", i), n_acc, vecs[i].nacc);
            check($sformatf("v%0d_done_onehot", i), n_multi, 0);
            if (vecs[i].nacc >= 1)
                check($sformatf("v%0d_acc0", i), {acc_addr[0], acc_wr[0][0]},
                      {vecs[i].a0, vecs[i].w0[0]});
            if (vecs[i].nacc >= 2)
                check($sformatf("v%0d_acc1", i), {acc_addr[1], acc_wr[1][0]},
                      {vecs[i].a1, vecs[i].w1[0]});
            @(posedge clock); #1;
            check_dbg($sformatf("v%0d_dbg_c0", i), 0, int'(vecs[i].addr[1:0]), vecs[i].st0);
            check_dbg($sformatf("v%0d_dbg_c1", i), 1, int'(vecs[i].addr[1:0]), vecs[i].st1);
        end

        // Simultaneous requests with the pointer at 0: core0 first, then core1.
        lat = 0;
        set_req(0, 0, 8'h26);
        set_req(1, 0, 8'h11);
        run_until(2);
        check("rr1_first", done_core[0], 0);
        check("rr1_second", done_core[1], 1);
        check("rr1_hits", {done_hit[0][0], done_hit[1][0]}, 2'b00);
        check("rr1_owner_abort", n_abort, 1);
        @(posedge clock); #1;
        check_dbg("rr1_dbg_c0_i1", 0, 1, 1);
        check_dbg("rr1_dbg_c1_i1", 1, 1, 1);
        check_dbg("rr1_dbg_c1_i2", 1, 2, 1);

        // Pointer must be back at 0: core0 again wins, both hit.
        set_req(0, 0, 8'h11);
        set_req(1, 0, 8'h26);
        run_until(2);
        check("rr2_first", done_core[0], 0);
        check("rr2_second", done_core[1], 1);
        check("rr2_hits", {done_hit[0][0], done_hit[1][0]}, 2'b11);
        check("rr2_latency", {done_cyc[0][7:0], done_cyc[1][7:0]}, {8'd2, 8'd5});
        check("rr2_no_mem", n_acc, 0);
        @(posedge clock); #1;

        // Reset asserted while a fill is outstanding.
        begin
            int  cyc = 0;
            int  extra = 0;
            set_req(0, 0, 8'h30);
            while (!(mem_req && !mem_write) && cyc < 20) begin
                @(posedge clock); #1;
                cyc++;
            end
            check("rst_fill_seen", {mem_req, mem_write}, 2'b10);
            check("rst_fill_addr", mem_addr, 8'h30);
            #2;
            reset_n = 1'b0;
            #1;
            check("rst_mem_req_drop", mem_req, 0);
            check("rst_no_done", req_done, 0);
            for (int c = 0; c < NC; c++)
                for (int l = 0; l < 4; l++)
                    check($sformatf("rst_dbg_c%0d_i%0d", c, l), {30'd0, dbg_state_of(c, l)}, 0);
            req_valid = '0;
            @(negedge clock) reset_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(posedge clock); #1;
                if (req_done != '0 || mem_req) extra++;
            end
            check("rst_quiet_after", extra, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [1:0] dbg_state_of(input int core, input int idx);
        return dut.line_q[core][idx];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
